// File: rtl/lrwait_qnode_multi.sv
// -----------------------------------------------------------------------------
// lrwait_qnode_multi
//
// Queue node for LR/SC reservations with LR-wait support, sitting between a
// Snitch core and its tile interconnect. Up to NumSlots independent
// reservations are tracked. When a reservation ends with a known successor
// (announced by a SuccUpdate response), the node inserts a wakeup LR beat
// towards the tile so the successor is released.
//
// Ports
//   clk_i, rst_i         : clock, synchronous active-high reset
//   snitch_q*            : request channel from Snitch (valid/ready)
//   snitch_p*            : response channel to Snitch (valid/ready)
//   tile_q*              : request channel to tile, tile_qlrwait_o marks wakeups
//   tile_p*              : response channel from tile, tile_plrwait_i marks
//                          SuccUpdate beats that are absorbed here
//   slots_busy_o         : one bit per slot, set while the slot is not Idle
//   orphan_update_o      : pulses while a SuccUpdate matching no slot is dropped
// -----------------------------------------------------------------------------
module lrwait_qnode_multi #(
    parameter int NumSlots  = 2,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int IdWidth   = 4,
    parameter int MetaWidth = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic [AddrWidth-1:0]   snitch_qaddr_i,
    input  logic                   snitch_qwrite_i,
    input  logic [3:0]             snitch_qamo_i,
    input  logic [DataWidth-1:0]   snitch_qdata_i,
    input  logic [DataWidth/8-1:0] snitch_qstrb_i,
    input  logic [IdWidth-1:0]     snitch_qid_i,
    input  logic                   snitch_qvalid_i,
    output logic                   snitch_qready_o,

    output logic [DataWidth-1:0]   snitch_pdata_o,
    output logic                   snitch_perror_o,
    output logic [IdWidth-1:0]     snitch_pid_o,
    output logic                   snitch_pvalid_o,
    input  logic                   snitch_pready_i,

    output logic [AddrWidth-1:0]   tile_qaddr_o,
    output logic                   tile_qwrite_o,
    output logic [3:0]             tile_qamo_o,
    output logic [DataWidth-1:0]   tile_qdata_o,
    output logic [DataWidth/8-1:0] tile_qstrb_o,
    output logic [IdWidth-1:0]     tile_qid_o,
    output logic                   tile_qlrwait_o,
    output logic                   tile_qvalid_o,
    input  logic                   tile_qready_i,

    input  logic [DataWidth-1:0]   tile_pdata_i,
    input  logic                   tile_perror_i,
    input  logic [IdWidth-1:0]     tile_pid_i,
    input  logic                   tile_plrwait_i,
    input  logic                   tile_pvalid_i,
    output logic                   tile_pready_o,

    output logic [NumSlots-1:0]    slots_busy_o,
    output logic                   orphan_update_o
);

    localparam int IdxW = (NumSlots > 1) ? $clog2(NumSlots) : 1;

    localparam logic [3:0] AMO_LR = 4'hA;
    localparam logic [3:0] AMO_SC = 4'hB;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LR_PEND   = 3'd1;
    localparam logic [2:0] ST_RESERVED  = 3'd2;
    localparam logic [2:0] ST_QUEUED    = 3'd3;
    localparam logic [2:0] ST_SC_PEND   = 3'd4;
    localparam logic [2:0] ST_WAKE_PEND = 3'd5;

    // Slot storage
    logic [2:0]           state_q     [NumSlots];
    logic [2:0]           state_d     [NumSlots];
    logic [AddrWidth-1:0] addr_q      [NumSlots];
    logic [AddrWidth-1:0] addr_d      [NumSlots];
    logic [IdWidth-1:0]   id_q        [NumSlots];
    logic [IdWidth-1:0]   id_d        [NumSlots];
    logic [MetaWidth-1:0] meta_q      [NumSlots];
    logic [MetaWidth-1:0] meta_d      [NumSlots];
    logic [NumSlots-1:0]  succ_seen_q;
    logic [NumSlots-1:0]  succ_seen_d;

    // Wakeup arbitration state
    logic [IdxW-1:0]      rr_ptr_q;
    logic [IdxW-1:0]      rr_ptr_d;
    logic                 wake_lock_q;
    logic                 wake_lock_d;
    logic [IdxW-1:0]      wake_sel_q;
    logic [IdxW-1:0]      wake_sel_d;

    // Decode results
    logic                 is_lr;
    logic                 is_sc;
    logic [NumSlots-1:0]  busy_vec;
    logic [NumSlots-1:0]  lr_addr_match;
    logic [NumSlots-1:0]  sc_cand;
    logic [NumSlots-1:0]  succ_cand;
    logic [NumSlots-1:0]  resp_match;
    logic [NumSlots-1:0]  wake_pend;

    logic [NumSlots-1:0]  alloc_onehot;
    logic [NumSlots-1:0]  sc_onehot;
    logic [NumSlots-1:0]  succ_onehot;
    logic                 idle_found;
    logic                 sc_found;
    logic                 succ_found;

    logic                 rr_found;
    logic [IdxW-1:0]      rr_sel;
    logic [IdxW-1:0]      wake_sel;
    logic [IdxW-1:0]      rr_next;
    logic [AddrWidth-1:0] wake_addr;
    logic [IdWidth-1:0]   wake_id;
    logic [MetaWidth-1:0] wake_meta;

    // Control
    logic                 wake_any;
    logic                 wake_valid;
    logic                 lr_stall;
    logic                 snitch_hs;
    logic                 alloc_hs;
    logic                 sc_hs;
    logic                 wake_hs;
    logic                 succ_upd;
    logic                 resp_hs;

    logic [NumSlots-1:0]  alloc_hit;
    logic [NumSlots-1:0]  sc_hit;
    logic [NumSlots-1:0]  succ_hit;
    logic [NumSlots-1:0]  resp_hit;
    logic [NumSlots-1:0]  wake_hit;

    // Per-slot comparisons against the incoming request and response.
    always_comb begin
        is_lr         = (snitch_qamo_i == AMO_LR);
        is_sc         = (snitch_qamo_i == AMO_SC);
        busy_vec      = '0;
        lr_addr_match = '0;
        sc_cand       = '0;
        succ_cand     = '0;
        resp_match    = '0;
        wake_pend     = '0;
        for (int i = 0; i < NumSlots; i++) begin
            busy_vec[i]      = (state_q[i] != ST_IDLE);
            lr_addr_match[i] = busy_vec[i] && (addr_q[i] == snitch_qaddr_i);
            sc_cand[i]       = ((state_q[i] == ST_RESERVED) || (state_q[i] == ST_QUEUED))
                               && (addr_q[i] == snitch_qaddr_i);
            succ_cand[i]     = busy_vec[i] && (id_q[i] == tile_pid_i);
            resp_match[i]    = ((state_q[i] == ST_LR_PEND) || (state_q[i] == ST_SC_PEND))
                               && (id_q[i] == tile_pid_i);
            wake_pend[i]     = (state_q[i] == ST_WAKE_PEND);
        end
    end

    // Lowest-index selection for allocation, SC targeting and SuccUpdate
    // targeting; ids and addresses are normally unique, so this only breaks ties.
    always_comb begin
        alloc_onehot = '0;
        sc_onehot    = '0;
        succ_onehot  = '0;
        idle_found   = 1'b0;
        sc_found     = 1'b0;
        succ_found   = 1'b0;
        for (int i = 0; i < NumSlots; i++) begin
            if (!idle_found && !busy_vec[i]) begin
                alloc_onehot[i] = 1'b1;
                idle_found      = 1'b1;
            end
            if (!sc_found && sc_cand[i]) begin
                sc_onehot[i] = 1'b1;
                sc_found     = 1'b1;
            end
            if (!succ_found && succ_cand[i]) begin
                succ_onehot[i] = 1'b1;
                succ_found     = 1'b1;
            end
        end
    end

    // Round-robin pick among WakePend slots starting at the pointer. Once a
    // beat has been shown without a handshake, the lock keeps the same slot
    // on the bus even if a higher-priority slot becomes WakePend meanwhile.
    always_comb begin
        rr_found  = 1'b0;
        rr_sel    = '0;
        for (int k = 0; k < NumSlots; k++) begin
            for (int i = 0; i < NumSlots; i++) begin
                if (!rr_found && wake_pend[i] && (((int'(rr_ptr_q) + k) % NumSlots) == i)) begin
                    rr_found = 1'b1;
                    rr_sel   = IdxW'(i);
                end
            end
        end
        wake_sel  = wake_lock_q ? wake_sel_q : rr_sel;
        wake_addr = '0;
        wake_id   = '0;
        wake_meta = '0;
        rr_next   = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (wake_sel == IdxW'(i)) begin
                wake_addr = addr_q[i];
                wake_id   = id_q[i];
                wake_meta = meta_q[i];
                rr_next   = IdxW'((i + 1) % NumSlots);
            end
        end
    end

    // Handshake qualification and the request/response datapaths. Reset
    // gates every valid so nothing escapes while state is being cleared.
    always_comb begin
        wake_any   = |wake_pend;
        wake_valid = !rst_i && wake_any;
        lr_stall   = snitch_qvalid_i && is_lr && !(|lr_addr_match) && !idle_found;

        snitch_qready_o = !rst_i && !wake_any && !lr_stall && tile_qready_i;
        tile_qvalid_o   = !rst_i && (wake_any || (snitch_qvalid_i && !lr_stall));

        snitch_hs = snitch_qvalid_i && snitch_qready_o;
        alloc_hs  = snitch_hs && is_lr && !(|lr_addr_match);
        sc_hs     = snitch_hs && is_sc;
        wake_hs   = wake_valid && tile_qready_i;
        succ_upd  = tile_pvalid_i && tile_plrwait_i;
        resp_hs   = tile_pvalid_i && !tile_plrwait_i && snitch_pready_i;

        orphan_update_o = !rst_i && succ_upd && !succ_found;

        tile_qstrb_o = snitch_qstrb_i;
        if (wake_any) begin
            tile_qaddr_o  = wake_addr;
            tile_qwrite_o = 1'b0;
            tile_qamo_o   = AMO_LR;
            tile_qdata_o  = DataWidth'(wake_meta);
            tile_qid_o    = wake_id;
        end else begin
            tile_qaddr_o  = snitch_qaddr_i;
            tile_qwrite_o = snitch_qwrite_i;
            tile_qamo_o   = snitch_qamo_i;
            tile_qdata_o  = snitch_qdata_i;
            tile_qid_o    = snitch_qid_i;
        end
        tile_qlrwait_o = wake_valid;

        snitch_pdata_o  = tile_pdata_i;
        snitch_perror_o = tile_perror_i;
        snitch_pid_o    = tile_pid_i;
        snitch_pvalid_o = !rst_i && tile_pvalid_i && !tile_plrwait_i;
        tile_pready_o   = tile_plrwait_i ? 1'b1 : snitch_pready_i;

        slots_busy_o = rst_i ? '0 : busy_vec;

        alloc_hit = alloc_hs ? alloc_onehot : '0;
        sc_hit    = sc_hs ? sc_onehot : '0;
        succ_hit  = succ_upd ? succ_onehot : '0;
        resp_hit  = resp_hs ? resp_match : '0;
        wake_hit  = '0;
        for (int i = 0; i < NumSlots; i++) begin
            wake_hit[i] = wake_hs && (wake_sel == IdxW'(i));
        end
    end

    // Slot state machine. A SuccUpdate always refreshes meta on its target;
    // the state change depends on where the reservation currently stands.
    always_comb begin
        rr_ptr_d    = wake_hs ? rr_next : rr_ptr_q;
        wake_lock_d = wake_valid && !tile_qready_i;
        wake_sel_d  = wake_sel;
        succ_seen_d = succ_seen_q;
        for (int i = 0; i < NumSlots; i++) begin
            state_d[i] = state_q[i];
            addr_d[i]  = addr_q[i];
            id_d[i]    = id_q[i];
            meta_d[i]  = meta_q[i];

            if (succ_hit[i]) begin
                meta_d[i] = tile_pdata_i[MetaWidth-1:0];
            end

            case (state_q[i])
                ST_IDLE: begin
                    if (alloc_hit[i]) begin
                        state_d[i]     = ST_LR_PEND;
                        addr_d[i]      = snitch_qaddr_i;
                        id_d[i]        = snitch_qid_i;
                        meta_d[i]      = '0;
                        succ_seen_d[i] = 1'b0;
                    end
                end
                ST_LR_PEND: begin
                    if (succ_hit[i]) begin
                        succ_seen_d[i] = 1'b1;
                    end
                    if (resp_hit[i]) begin
                        state_d[i] = (succ_seen_q[i] || succ_hit[i]) ? ST_QUEUED : ST_RESERVED;
                    end
                end
                ST_RESERVED: begin
                    if (sc_hit[i]) begin
                        id_d[i]    = snitch_qid_i;
                        state_d[i] = succ_hit[i] ? ST_WAKE_PEND : ST_SC_PEND;
                    end else if (succ_hit[i]) begin
                        state_d[i] = ST_QUEUED;
                    end
                end
                ST_QUEUED: begin
                    if (sc_hit[i]) begin
                        id_d[i]    = snitch_qid_i;
                        state_d[i] = ST_WAKE_PEND;
                    end
                end
                ST_SC_PEND: begin
                    // A successor arriving alongside the SC response must
                    // still be woken, so the SuccUpdate wins.
                    if (succ_hit[i]) begin
                        state_d[i] = ST_WAKE_PEND;
                    end else if (resp_hit[i]) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                ST_WAKE_PEND: begin
                    if (wake_hit[i]) begin
                        state_d[i]     = ST_IDLE;
                        succ_seen_d[i] = 1'b0;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase
        end
    end

    // Register update with synchronous reset clearing every slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumSlots; i++) begin
                state_q[i] <= ST_IDLE;
                addr_q[i]  <= '0;
                id_q[i]    <= '0;
                meta_q[i]  <= '0;
            end
            succ_seen_q <= '0;
            rr_ptr_q    <= '0;
            wake_lock_q <= 1'b0;
            wake_sel_q  <= '0;
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                state_q[i] <= state_d[i];
                addr_q[i]  <= addr_d[i];
                id_q[i]    <= id_d[i];
                meta_q[i]  <= meta_d[i];
            end
            succ_seen_q <= succ_seen_d;
            rr_ptr_q    <= rr_ptr_d;
            wake_lock_q <= wake_lock_d;
            wake_sel_q  <= wake_sel_d;
        end
    end

endmodule

// File: tb/tb_lrwait_qnode_multi.sv
// -----------------------------------------------------------------------------
// tb_lrwait_qnode_multi
//
// Directed bench for lrwait_qnode_multi with two slots. Each scenario starts
// from reset, drives request/response vectors cycle by cycle and compares the
// outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_lrwait_qnode_multi;

    logic        clk_i = 1'b0;
    logic        rst_i;

    logic [31:0] snitch_qaddr_i;
    logic        snitch_qwrite_i;
    logic [3:0]  snitch_qamo_i;
    logic [31:0] snitch_qdata_i;
    logic [3:0]  snitch_qstrb_i;
    logic [3:0]  snitch_qid_i;
    logic        snitch_qvalid_i;
    logic        snitch_qready_o;
    logic [31:0] snitch_pdata_o;
    logic        snitch_perror_o;
    logic [3:0]  snitch_pid_o;
    logic        snitch_pvalid_o;
    logic        snitch_pready_i;
    logic [31:0] tile_qaddr_o;
    logic        tile_qwrite_o;
    logic [3:0]  tile_qamo_o;
    logic [31:0] tile_qdata_o;
    logic [3:0]  tile_qstrb_o;
    logic [3:0]  tile_qid_o;
    logic        tile_qlrwait_o;
    logic        tile_qvalid_o;
    logic        tile_qready_i;
    logic [31:0] tile_pdata_i;
    logic        tile_perror_i;
    logic [3:0]  tile_pid_i;
    logic        tile_plrwait_i;
    logic        tile_pvalid_i;
    logic        tile_pready_o;
    logic [1:0]  slots_busy_o;
    logic        orphan_update_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    lrwait_qnode_multi #(
        .NumSlots (2),
        .AddrWidth(32),
        .DataWidth(32),
        .IdWidth  (4),
        .MetaWidth(16)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .snitch_qaddr_i (snitch_qaddr_i),
        .snitch_qwrite_i(snitch_qwrite_i),
        .snitch_qamo_i  (snitch_qamo_i),
        .snitch_qdata_i (snitch_qdata_i),
        .snitch_qstrb_i (snitch_qstrb_i),
        .snitch_qid_i   (snitch_qid_i),
        .snitch_qvalid_i(snitch_qvalid_i),
        .snitch_qready_o(snitch_qready_o),
        .snitch_pdata_o (snitch_pdata_o),
        .snitch_perror_o(snitch_perror_o),
        .snitch_pid_o   (snitch_pid_o),
        .snitch_pvalid_o(snitch_pvalid_o),
        .snitch_pready_i(snitch_pready_i),
        .tile_qaddr_o   (tile_qaddr_o),
        .tile_qwrite_o  (tile_qwrite_o),
        .tile_qamo_o    (tile_qamo_o),
        .tile_qdata_o   (tile_qdata_o),
        .tile_qstrb_o   (tile_qstrb_o),
        .tile_qid_o     (tile_qid_o),
        .tile_qlrwait_o (tile_qlrwait_o),
        .tile_qvalid_o  (tile_qvalid_o),
        .tile_qready_i  (tile_qready_i),
        .tile_pdata_i   (tile_pdata_i),
        .tile_perror_i  (tile_perror_i),
        .tile_pid_i     (tile_pid_i),
        .tile_plrwait_i (tile_plrwait_i),
        .tile_pvalid_i  (tile_pvalid_i),
        .tile_pready_o  (tile_pready_o),
        .slots_busy_o   (slots_busy_o),
        .orphan_update_o(orphan_update_o)
    );

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive the Snitch request channel, then let combinational outputs settle.
    task automatic applyStimulus(input logic valid, input logic [3:0] amo,
                                 input logic [31:0] addr, input logic [3:0] id,
                                 input logic write, input logic [31:0] data);
        snitch_qvalid_i = valid;
        snitch_qamo_i   = amo;
        snitch_qaddr_i  = addr;
        snitch_qid_i    = id;
        snitch_qwrite_i = write;
        snitch_qdata_i  = data;
        snitch_qstrb_i  = write ? 4'hF : 4'h0;
        #1;
    endtask

    // Drive the tile response channel, then let outputs settle.
    task automatic applyResponse(input logic valid, input logic lrwait,
                                 input logic [3:0] pid, input logic [31:0] data,
                                 input logic err);
        tile_pvalid_i  = valid;
        tile_plrwait_i = lrwait;
        tile_pid_i     = pid;
        tile_pdata_i   = data;
        tile_perror_i  = err;
        #1;
    endtask

    task automatic idleInputs();
        snitch_qvalid_i = 1'b0;
        snitch_qamo_i   = 4'h0;
        snitch_qaddr_i  = 32'h0;
        snitch_qid_i    = 4'h0;
        snitch_qwrite_i = 1'b0;
        snitch_qdata_i  = 32'h0;
        snitch_qstrb_i  = 4'h0;
        snitch_pready_i = 1'b1;
        tile_qready_i   = 1'b1;
        tile_pvalid_i   = 1'b0;
        tile_plrwait_i  = 1'b0;
        tile_pid_i      = 4'h0;
        tile_pdata_i    = 32'h0;
        tile_perror_i   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic doReset();
        idleInputs();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        // ---------------- reset state, with live inputs held high ----------
        idleInputs();
        rst_i = 1'b1;
        applyStimulus(1'b1, 4'hA, 32'h100, 4'd3, 1'b0, 32'h0);
        applyResponse(1'b1, 1'b0, 4'd3, 32'h55, 1'b0);
        checkOutput("rst_tile_qvalid",   64'(tile_qvalid_o),   64'h0);
        checkOutput("rst_snitch_pvalid", 64'(snitch_pvalid_o), 64'h0);
        checkOutput("rst_qlrwait",       64'(tile_qlrwait_o),  64'h0);
        checkOutput("rst_busy",          64'(slots_busy_o),    64'h0);
        applyResponse(1'b1, 1'b1, 4'd7, 32'h0, 1'b0);
        checkOutput("rst_orphan",        64'(orphan_update_o), 64'h0);
        step();
        step();
        idleInputs();
        rst_i = 1'b0;
        #1;
        checkOutput("post_rst_busy",   64'(slots_busy_o),  64'h0);
        checkOutput("post_rst_qvalid", 64'(tile_qvalid_o), 64'h0);

        // ---------------- plain LR / SC without successor ------------------
        doReset();
        applyStimulus(1'b1, 4'hA, 32'h100, 4'd3, 1'b0, 32'h0);
        checkOutput("a_lr_qready", 64'(snitch_qready_o), 64'h1);
        checkOutput("a_lr_qvalid", 64'(tile_qvalid_o),   64'h1);
        checkOutput("a_lr_amo",    64'(tile_qamo_o),     64'hA);
        checkOutput("a_lr_lrwait", 64'(tile_qlrwait_o),  64'h0);
        step();
        idleInputs();
        applyResponse(1'b1, 1'b0, 4'd3, 32'h55, 1'b0);
        checkOutput("a_busy_lrpend", 64'(slots_busy_o),    64'h1);
        checkOutput("a_resp_pvalid", 64'(snitch_pvalid_o), 64'h1);
        checkOutput("a_resp_pdata",  64'(snitch_pdata_o),  64'h55);
        checkOutput("a_resp_pready", 64'(tile_pready_o),   64'h1);
        step();
        idleInputs();
        applyStimulus(1'b1, 4'hB, 32'h100, 4'd5, 1'b0, 32'h0);
        checkOutput("a_sc_qready", 64'(snitch_qready_o), 64'h1);
        checkOutput("a_sc_amo",    64'(tile_qamo_o),     64'hB);
        step();
        idleInputs();
        applyResponse(1'b1, 1'b0, 4'd5, 32'h0, 1'b1);
        checkOutput("a_busy_scpend", 64'(slots_busy_o),    64'h1);
        checkOutput("a_sc_perror",   64'(snitch_perror_o), 64'h1);
        checkOutput("a_sc_pid",      64'(snitch_pid_o),    64'h5);
        step();
        idleInputs();
        #1;
        checkOutput("a_busy_idle", 64'(slots_busy_o),  64'h0);
        checkOutput("a_no_wake",   64'(tile_qvalid_o), 64'h0);
        step();
        checkOutput("a_no_wake2",  64'(tile_qvalid_o), 64'h0);
        applyStimulus(1'b1, 4'h0, 32'h40, 4'd2, 1'b1, 32'hDEADBEEF);
        checkOutput("a_wr_qwrite", 64'(tile_qwrite_o), 64'h1);
        checkOutput("a_wr_qstrb",  64'(tile_qstrb_o),  64'hF);
        checkOutput("a_wr_qdata",  64'(tile_qdata_o),  64'hDEADBEEF);

        // ---------------- successor known before LR response ---------------
        doReset();
        applyStimulus(1'b1, 4'hA, 32'h100, 4'd3, 1'b0, 32'h0);
        step();
        idleInputs();
        snitch_pready_i = 1'b0;
        applyResponse(1'b1, 1'b1, 4'd3, 32'h000000AB, 1'b0);
        checkOutput("b_succ_pvalid", 64'(snitch_pvalid_o), 64'h0);
        checkOutput("b_succ_pready", 64'(tile_pready_o),   64'h1);
        checkOutput("b_succ_orphan", 64'(orphan_update_o), 64'h0);
        step();
        idleInputs();
        applyResponse(1'b1, 1'b0, 4'd3, 32'h0, 1'b0);
        step();
        idleInputs();
        applyStimulus(1'b1, 4'hB, 32'h100, 4'd6, 1'b0, 32'h0);
        checkOutput("b_sc_qready",  64'(snitch_qready_o), 64'h1);
        checkOutput("b_sc_nowake",  64'(tile_qlrwait_o),  64'h0);
        step();
        idleInputs();
        applyStimulus(1'b1, 4'h0, 32'h80, 4'd1, 1'b0, 32'h0);
        checkOutput("b_wk_qvalid",  64'(tile_qvalid_o),   64'h1);
        checkOutput("b_wk_lrwait",  64'(tile_qlrwait_o),  64'h1);
        checkOutput("b_wk_addr",    64'(tile_qaddr_o),    64'h100);
        checkOutput("b_wk_data",    64'(tile_qdata_o),    64'h000000AB);
        checkOutput("b_wk_amo",     64'(tile_qamo_o),     64'hA);
        checkOutput("b_wk_id",      64'(tile_qid_o),      64'h6);
        checkOutput("b_wk_qwrite",  64'(tile_qwrite_o),   64'h0);
        checkOutput("b_wk_sqready", 64'(snitch_qready_o), 64'h0);
        step();
        idleInputs();
        #1;
        checkOutput("b_after_busy",   64'(slots_busy_o),   64'h0);
        checkOutput("b_after_lrwait", 64'(tile_qlrwait_o), 64'h0);

        // ---------------- slot exhaustion and nested LR --------------------
        doReset();
        applyStimulus(1'b1, 4'hA, 32'h100, 4'd1, 1'b0, 32'h0);
        step();
        applyStimulus(1'b1, 4'hA, 32'h200, 4'd2, 1'b0, 32'h0);
        step();
        applyStimulus(1'b1, 4'hA, 32'h300, 4'd3, 1'b0, 32'h0);
        checkOutput("c_busy_full",    64'(slots_busy_o),    64'h3);
        checkOutput("c_stall_qready", 64'(snitch_qready_o), 64'h0);
        checkOutput("c_stall_qvalid", 64'(tile_qvalid_o),   64'h0);
        step();
        checkOutput("c_stall2_qready", 64'(snitch_qready_o), 64'h0);
        applyStimulus(1'b1, 4'h0, 32'h300, 4'd3, 1'b0, 32'h0);
        checkOutput("c_read_passes",  64'(snitch_qready_o), 64'h1);
        applyStimulus(1'b1, 4'hA, 32'h100, 4'd4, 1'b0, 32'h0);
        checkOutput("c_nested_qready", 64'(snitch_qready_o), 64'h1);
        checkOutput("c_nested_qvalid", 64'(tile_qvalid_o),   64'h1);
        step();
        idleInputs();
        applyResponse(1'b1, 1'b0, 4'd1, 32'h0, 1'b0);
        checkOutput("c_nested_busy", 64'(slots_busy_o), 64'h3);
        step();
        idleInputs();
        applyStimulus(1'b1, 4'hB, 32'h100, 4'd7, 1'b0, 32'h0);
        step();
        idleInputs();
        applyResponse(1'b1, 1'b0, 4'd7, 32'h0, 1'b0);
        step();
        idleInputs();
        applyStimulus(1'b1, 4'hA, 32'h300, 4'd3, 1'b0, 32'h0);
        checkOutput("c_freed_busy",   64'(slots_busy_o),    64'h2);
        checkOutput("c_freed_qready", 64'(snitch_qready_o), 64'h1);
        step();
        idleInputs();
        #1;
        checkOutput("c_realloc_busy", 64'(slots_busy_o), 64'h3);

        // ---------------- two simultaneous wakeups, held bus ---------------
        doReset();
        applyStimulus(1'b1, 4'hA, 32'h100, 4'd1, 1'b0, 32'h0);
        step();
        applyStimulus(1'b1, 4'hA, 32'h200, 4'd2, 1'b0, 32'h0);
        step();
        idleInputs();
        applyResponse(1'b1, 1'b1, 4'd1, 32'h00000011, 1'b0);
        step();
        idleInputs();
        applyResponse(1'b1, 1'b0, 4'd1, 32'h0, 1'b0);
        step();
        idleInputs();
        applyResponse(1'b1, 1'b0, 4'd2, 32'h0, 1'b0);
        step();
        idleInputs();
        applyStimulus(1'b1, 4'hB, 32'h200, 4'd9, 1'b0, 32'h0);
        step();
        idleInputs();
        applyStimulus(1'b1, 4'hB, 32'h100, 4'd8, 1'b0, 32'h0);
        applyResponse(1'b1, 1'b1, 4'd9, 32'h00000022, 1'b0);
        checkOutput("d_trig_qready", 64'(snitch_qready_o), 64'h1);
        checkOutput("d_trig_orphan", 64'(orphan_update_o), 64'h0);
        step();
        idleInputs();
        tile_qready_i = 1'b0;
        applyStimulus(1'b1, 4'h0, 32'h44, 4'd5, 1'b0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            checkOutput("d_hold_qvalid",  64'(tile_qvalid_o),   64'h1);
            checkOutput("d_hold_addr",    64'(tile_qaddr_o),    64'h100);
            checkOutput("d_hold_data",    64'(tile_qdata_o),    64'h11);
            checkOutput("d_hold_id",      64'(tile_qid_o),      64'h8);
            checkOutput("d_hold_sqready", 64'(snitch_qready_o), 64'h0);
            step();
        end
        tile_qready_i = 1'b1;
        #1;
        checkOutput("d_s0_addr",    64'(tile_qaddr_o),    64'h100);
        checkOutput("d_s0_sqready", 64'(snitch_qready_o), 64'h0);
        step();
        checkOutput("d_s1_qvalid",  64'(tile_qvalid_o),   64'h1);
        checkOutput("d_s1_lrwait",  64'(tile_qlrwait_o),  64'h1);
        checkOutput("d_s1_addr",    64'(tile_qaddr_o),    64'h200);
        checkOutput("d_s1_data",    64'(tile_qdata_o),    64'h22);
        checkOutput("d_s1_id",      64'(tile_qid_o),      64'h9);
        checkOutput("d_s1_sqready", 64'(snitch_qready_o), 64'h0);
        step();
        checkOutput("d_end_sqready", 64'(snitch_qready_o), 64'h1);
        checkOutput("d_end_lrwait",  64'(tile_qlrwait_o),  64'h0);
        checkOutput("d_end_addr",    64'(tile_qaddr_o),    64'h44);
        checkOutput("d_end_busy",    64'(slots_busy_o),    64'h0);

        // ---------------- orphan SuccUpdate --------------------------------
        doReset();
        snitch_pready_i = 1'b1;
        applyResponse(1'b1, 1'b1, 4'hE, 32'h0000BEEF, 1'b0);
        checkOutput("e_orphan",        64'(orphan_update_o), 64'h1);
        checkOutput("e_orphan_pvalid", 64'(snitch_pvalid_o), 64'h0);
        checkOutput("e_orphan_pready", 64'(tile_pready_o),   64'h1);
        step();
        idleInputs();
        #1;
        checkOutput("e_orphan_gone", 64'(orphan_update_o), 64'h0);
        checkOutput("e_orphan_busy", 64'(slots_busy_o),    64'h0);

        // ---------------- reset while a wakeup is pending ------------------
        doReset();
        applyStimulus(1'b1, 4'hA, 32'h100, 4'd1, 1'b0, 32'h0);
        step();
        idleInputs();
        applyResponse(1'b1, 1'b0, 4'd1, 32'h0, 1'b0);
        step();
        idleInputs();
        applyStimulus(1'b1, 4'hB, 32'h100, 4'd2, 1'b0, 32'h0);
        applyResponse(1'b1, 1'b1, 4'd1, 32'h00000033, 1'b0);
        step();
        idleInputs();
        tile_qready_i = 1'b0;
        #1;
        checkOutput("f_wake_lrwait", 64'(tile_qlrwait_o), 64'h1);
        checkOutput("f_wake_data",   64'(tile_qdata_o),   64'h33);
        checkOutput("f_wake_id",     64'(tile_qid_o),     64'h2);
        rst_i = 1'b1;
        #1;
        checkOutput("f_rst_qvalid", 64'(tile_qvalid_o),  64'h0);
        checkOutput("f_rst_lrwait", 64'(tile_qlrwait_o), 64'h0);
        checkOutput("f_rst_busy",   64'(slots_busy_o),   64'h0);
        step();
        rst_i = 1'b0;
        tile_qready_i = 1'b1;
        #1;
        checkOutput("f_post_qvalid", 64'(tile_qvalid_o),  64'h0);
        checkOutput("f_post_busy",   64'(slots_busy_o),   64'h0);
        step();
        checkOutput("f_post2_lrwait", 64'(tile_qlrwait_o), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lrwait_qnode_multi.md
LRWAIT_QNODE_MULTI -- requirements
Module: lrwait_qnode_multi

Interface
REQ-001 SHALL have parameter NumSlots, default 2: independent reservation slots, range 1..8.
REQ-002 SHALL have parameter AddrWidth, default 32: request address width.
REQ-003 SHALL have parameter DataWidth, default 32: data width.
REQ-004 SHALL have parameter IdWidth, default 4: transaction id width.
REQ-005 SHALL have parameter MetaWidth, default 16: successor metadata width, at most DataWidth.
REQ-006 SHALL have ports clk_i in 1, the single clock; rst_i in 1, reset, synchronous and active-high.
REQ-007 SHALL have Snitch request ports: snitch_qaddr_i in AddrWidth; snitch_qwrite_i in 1; snitch_qamo_i in 4; snitch_qdata_i in DataWidth; snitch_qstrb_i in DataWidth/8; snitch_qid_i in IdWidth; snitch_qvalid_i in 1; snitch_qready_o out 1.
REQ-008 SHALL have Snitch response ports: snitch_pdata_o out DataWidth; snitch_perror_o out 1; snitch_pid_o out IdWidth; snitch_pvalid_o out 1; snitch_pready_i in 1.
REQ-009 SHALL have tile request ports: tile_qaddr_o, tile_qwrite_o, tile_qamo_o, tile_qdata_o, tile_qstrb_o, tile_qid_o (widths as REQ-007); tile_qlrwait_o out 1; tile_qvalid_o out 1; tile_qready_i in 1.
REQ-010 SHALL have tile response ports: tile_pdata_i, tile_perror_i, tile_pid_i (widths as REQ-008); tile_plrwait_i in 1, marks a SuccUpdate; tile_pvalid_i in 1; tile_pready_o out 1.
REQ-011 SHALL have status ports: slots_busy_o out NumSlots, per-slot non-Idle; orphan_update_o out 1, single-cycle pulse.

Function
REQ-012 AMO encoding: LR=4'hA, SC=4'hB; all other codes pass through untracked.
REQ-013 Each slot SHALL hold: state, addr, id, meta, succ_seen.
REQ-014 Slot states SHALL be Idle, LrPend, Reserved, Queued, ScPend, WakePend.
REQ-015 Request path SHALL be combinational when no wakeup is being inserted; qstrb and qwrite always pass through.
REQ-016 An LR handshake whose address matches no non-Idle slot SHALL allocate the lowest-index Idle slot: addr and id stored, state LrPend, succ_seen=0.
REQ-017 An LR whose address matches a non-Idle slot SHALL be forwarded without allocation; the nested LR is legal.
REQ-018 An LR with no matching slot and no Idle slot SHALL stall: snitch_qready_o=0 and tile_qvalid_o=0. Non-LR requests are unaffected.
REQ-019 A response with tile_plrwait_i=0 SHALL pass through combinationally, including perror, with tile_pready_o=snitch_pready_i.
REQ-020 On a forwarded response handshake whose pid equals the id of a LrPend slot: succ_seen=1 moves the slot to Queued; otherwise to Reserved.
REQ-021 A SuccUpdate (tile_plrwait_i=1) SHALL never reach Snitch: snitch_pvalid_o=0, tile_pready_o=1 in the same cycle.
REQ-022 A SuccUpdate SHALL target the non-Idle slot with id==tile_pid_i and store meta=tile_pdata_i[MetaWidth-1:0]. Transitions: LrPend sets succ_seen=1; Reserved goes to Queued; ScPend goes to WakePend.
REQ-023 A SuccUpdate matching no slot SHALL be dropped and pulse orphan_update_o for 1 cycle.
REQ-024 An SC handshake to a matching slot address SHALL store the SC id. Transitions: Reserved goes to ScPend; Queued goes to WakePend.
REQ-025 A same-cycle SC handshake and SuccUpdate on a Reserved slot SHALL go directly to WakePend.
REQ-026 On a forwarded response handshake whose pid equals the id of a ScPend slot, the slot SHALL go to Idle.
REQ-027 Wakeup insertion: WakePend slots SHALL be arbitrated round-robin, with the pointer advancing past the winner after each handshake. A wakeup has priority over Snitch requests.
REQ-028 Wakeup beat: tile_qvalid_o=1, snitch_qready_o=0, amo=LR, addr=slot addr, id=slot id, data=zero-extended meta, qlrwait=1, qwrite=0.
REQ-029 Once a wakeup is presented, it SHALL be held stable until tile_qready_i. The slot goes to Idle on that handshake.
REQ-030 The earliest wakeup beat SHALL occur in the cycle after the triggering SC or SuccUpdate handshake.

Reset
REQ-031 While rst_i=1 at a clock edge, all slots SHALL be set to Idle with fields zero, and the RR pointer to 0. A reset mid-operation discards pending wakeups.
REQ-032 During and after reset: tile_qvalid_o=0, snitch_pvalid_o=0, tile_qlrwait_o=0, slots_busy_o=0, orphan_update_o=0.

Verification
REQ-033 LR to 0x100 with id 3, then resp pid 3 -> slot0 Reserved; SC to 0x100 -> slot0 ScPend; SC resp -> slot0 Idle; no wakeup issued.
REQ-034 LR to 0x100 id 3, then SuccUpdate pid 3 data 0x00AB before the LR resp -> slot0 goes Queued after the LR resp; SC -> next cycle a wakeup beat with addr 0x100, data 0x000000AB, lrwait=1.
REQ-035 NumSlots=2: LRs to 0x100, 0x200 and 0x300 -> third LR stalls until the first slot frees; an LR back to 0x100 while slot0 is busy proceeds without stall.
REQ-036 Two slots reach WakePend in the same cycle while tile_qready_i is held 0 for 3 cycles -> slot0 beat held stable, then slot1 next; Snitch requests stalled throughout.
REQ-037 SuccUpdate with an unknown pid -> orphan_update_o pulses, snitch_pvalid_o stays 0.
REQ-038 Assert rst_i while a wakeup is pending -> no wakeup beat after reset, and slots_busy_o=0.
